// File: rtl/stream_pooling_engine_pkg.sv
// Shared types and width helpers for the streaming pooling engine.
// Mode encoding, accumulator width and address width are derived here.
package pooling_pkg;

  typedef enum logic {
    MODE_AVG = 1'b0,
    MODE_MAX = 1'b1
  } pool_mode_e;

  // The accumulator must hold a full POOL x POOL sum of max-value pixels.
  function automatic int acc_w(input int resolution, input int pool);
    return resolution + 2 * $clog2(pool);
  endfunction

  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_pooling_engine_if.sv
// Pixel-in / pooled-pixel-out stream bundle with valid/ready on both sides.
// The slave modport is the pooling engine; the master modport is its environment.
interface stream_pooling_engine_if #(
  parameter int RESOLUTION = 8,
  parameter int AW         = 8
) ();
  logic                  mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [RESOLUTION-1:0] in_pixel;
  logic                  out_valid;
  logic                  out_ready;
  logic [RESOLUTION-1:0] out_pixel;
  logic [AW-1:0]         out_addr;
  logic                  out_last;

  modport master (
    output mode, in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_addr, out_last
  );

  modport slave (
    input  mode, in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_addr, out_last
  );
endinterface

// File: rtl/stream_pooling_engine_row_buffer.sv
// One row of partial window results, one entry per output column.
// Presents the combined (sum or max) value for the addressed entry and the incoming pixel.
module pool_row_buffer
  import pooling_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int ACC_W      = 10,
  parameter int OW         = 14,
  parameter int IW         = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IW-1:0]         idx_i,
  input  logic                  init_i,
  input  pool_mode_e            mode_i,
  input  logic [RESOLUTION-1:0] pixel_i,
  output logic [ACC_W-1:0]      combined_o
);

  logic [ACC_W-1:0] mem_q [OW];
  logic [ACC_W-1:0] entry;
  logic [ACC_W-1:0] pix_ext;

  assign entry   = mem_q[idx_i];
  assign pix_ext = ACC_W'(pixel_i);

  always_comb begin
    if (mode_i == MODE_MAX) combined_o = (entry > pix_ext) ? entry : pix_ext;
    else                    combined_o = entry + pix_ext;
  end

  // NOTE: no reset on the storage array; every entry is overwritten at window start before it is read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= init_i ? pix_ext : combined_o;
  end

endmodule

// File: rtl/stream_pooling_engine.sv
// Streaming POOL x POOL average/max pooling over a raster pixel stream.
// Holds the raster counters, frame mode latch, handshake and the registered output slot.
module stream_pooling_engine
  import pooling_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int POOL       = 2
) (
  input logic                    clk,
  input logic                    reset,
  stream_pooling_engine_if.slave bus
);

  localparam int OW    = IMG_W / POOL;
  localparam int OH    = IMG_H / POOL;
  localparam int NOUT  = OW * OH;
  localparam int PL    = $clog2(POOL);
  localparam int SHIFT = 2 * PL;
  localparam int ACC_W = acc_w(RESOLUTION, POOL);
  localparam int CW    = addr_w(IMG_W);
  localparam int RW    = addr_w(IMG_H);
  localparam int IW    = addr_w(OW);
  localparam int AW    = addr_w(NOUT);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  pool_mode_e            mode_q, mode_d, mode_eff;
  logic                  out_valid_q, out_valid_d;
  logic [RESOLUTION-1:0] out_pixel_q, out_pixel_d;
  logic [AW-1:0]         out_addr_q, out_addr_d;

  logic                  accept, out_xfer, frame_start, win_start, win_end;
  logic [IW-1:0]         idx;
  logic [ACC_W-1:0]      combined;
  logic [RESOLUTION-1:0] result;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = (out_addr_q == AW'(NOUT - 1));

  assign accept      = bus.in_valid && bus.in_ready;
  assign out_xfer    = out_valid_q && bus.out_ready;
  assign frame_start = (col_q == '0) && (row_q == '0);
  assign win_start   = (col_q[PL-1:0] == '0) && (row_q[PL-1:0] == '0);
  assign win_end     = (&col_q[PL-1:0]) && (&row_q[PL-1:0]);
  // The first pixel of a frame uses the live mode input; the rest use the latched copy.
  assign mode_eff    = frame_start ? pool_mode_e'(bus.mode) : mode_q;
  assign idx         = IW'(col_q >> PL);
  assign result      = (mode_eff == MODE_MAX) ? combined[RESOLUTION-1:0] : combined[ACC_W-1:SHIFT];

  pool_row_buffer #(
    .RESOLUTION (RESOLUTION),
    .ACC_W      (ACC_W),
    .OW         (OW),
    .IW         (IW)
  ) u_row_buffer (
    .clk        (clk),
    .we_i       (accept),
    .idx_i      (idx),
    .init_i     (win_start),
    .mode_i     (mode_eff),
    .pixel_i    (bus.in_pixel),
    .combined_o (combined)
  );

  // NOTE: every next-state variable takes its hold value first, so no path can infer a latch.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_addr_d  = out_addr_q;

    if (accept) begin
      if (frame_start) mode_d = pool_mode_e'(bus.mode);
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (out_xfer) begin
      out_valid_d = 1'b0;
      out_addr_d  = (out_addr_q == AW'(NOUT - 1)) ? '0 : out_addr_q + 1'b1;
    end
    // A window end arriving while the slot drains reloads it, so out_valid stays high.
    if (accept && win_end) begin
      out_valid_d = 1'b1;
      out_pixel_d = result;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= MODE_AVG;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_addr_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_addr_q  <= out_addr_d;
    end
  end

endmodule

// File: tb/tb_stream_pooling_engine.sv
// Directed bench for the pooling engine: a 4x4/POOL2 instance and an 8x8/POOL4 instance.
// Frame vectors come from a table; stall, mid-frame reset and back-to-back frames are hand sequences.
module tb_stream_pooling_engine;
  import pooling_pkg::*;

  localparam int AW = addr_w(4);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_pooling_engine_if #(.RESOLUTION(8), .AW(AW)) if_a ();
  stream_pooling_engine_if #(.RESOLUTION(8), .AW(AW)) if_b ();

  stream_pooling_engine #(.RESOLUTION(8), .IMG_W(4), .IMG_H(4), .POOL(2)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  stream_pooling_engine #(.RESOLUTION(8), .IMG_W(8), .IMG_H(8), .POOL(4)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  typedef struct {
    logic [7:0] pix;
    int         addr;
    logic       last;
  } out_rec_t;

  typedef struct {
    logic            sel;   // 0: 4x4 POOL2, 1: 8x8 POOL4
    logic            mode;
    int              mul;   // pixel i = i*mul + add
    int              add;
    logic [0:3][7:0] exp;
  } vec_t;

  out_rec_t q_a[$];
  out_rec_t q_b[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // An output is recorded when valid&&ready is seen between edges, i.e. it transfers on the next edge.
  always @(negedge clk) begin
    if (if_a.out_valid && if_a.out_ready)
      q_a.push_back('{if_a.out_pixel, int'(if_a.out_addr), if_a.out_last});
    if (if_b.out_valid && if_b.out_ready)
      q_b.push_back('{if_b.out_pixel, int'(if_b.out_addr), if_b.out_last});
  end

  task automatic drive(input logic sel, input logic valid, input logic mode, input logic [7:0] pix);
    if (sel) begin
      if_b.in_valid = valid; if_b.mode = mode; if_b.in_pixel = pix;
    end else begin
      if_a.in_valid = valid; if_a.mode = mode; if_a.in_pixel = pix;
    end
  endtask

  task automatic send_pixels(input logic sel, input logic mode, input int mul, input int add,
                             input int n, input int toggle_at);
    for (int i = 0; i < n; i++) begin
      int budget = 0;
      drive(sel, 1'b1, (i >= toggle_at) ? ~mode : mode, 8'(i * mul + add));
      forever begin
        @(negedge clk);
        if (sel ? if_b.in_ready : if_a.in_ready) break;
        budget++;
        if (budget > 50) begin
          check("in_ready_timeout", 0, 1);
          return;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input logic sel);
    drive(sel, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic check_frame(input logic sel, input logic [0:3][7:0] exp, input string tag,
                             input int n_expect);
    int size;
    out_rec_t rec;
    repeat (4) @(posedge clk);
    #1;
    size = sel ? q_b.size() : q_a.size();
    check($sformatf("%s_count", tag), size, n_expect);
    for (int j = 0; j < 4; j++) begin
      if (j < size) begin
        rec = sel ? q_b.pop_front() : q_a.pop_front();
        check($sformatf("%s_pix%0d", tag, j),  int'(rec.pix),  int'(exp[j]));
        check($sformatf("%s_addr%0d", tag, j), rec.addr,       j);
        check($sformatf("%s_last%0d", tag, j), int'(rec.last), (j == 3) ? 1 : 0);
      end
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, MODE_AVG, 1,   0,   {8'd2,   8'd4,   8'd10,  8'd12}};
    vecs[1] = '{1'b0, MODE_MAX, 1,   0,   {8'd5,   8'd7,   8'd13,  8'd15}};
    vecs[2] = '{1'b0, MODE_AVG, 16,  3,   {8'd43,  8'd75,  8'd171, 8'd203}};
    vecs[3] = '{1'b0, MODE_MAX, 16,  3,   {8'd83,  8'd115, 8'd211, 8'd243}};
    vecs[4] = '{1'b0, MODE_AVG, 1,   1,   {8'd3,   8'd5,   8'd11,  8'd13}};
    vecs[5] = '{1'b0, MODE_AVG, 0,   255, {8'd255, 8'd255, 8'd255, 8'd255}};
    vecs[6] = '{1'b1, MODE_AVG, 0,   255, {8'd255, 8'd255, 8'd255, 8'd255}};
    vecs[7] = '{1'b1, MODE_AVG, 1,   0,   {8'd13,  8'd17,  8'd45,  8'd49}};
    vecs[8] = '{1'b1, MODE_MAX, 1,   0,   {8'd27,  8'd31,  8'd59,  8'd63}};

    reset = 1'b0;
    if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
    idle(1'b0); idle(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  int'(if_a.in_ready),  1);
    check("rst_out_valid", int'(if_a.out_valid), 0);
    check("rst_out_pixel", int'(if_a.out_pixel), 0);
    check("rst_out_addr",  int'(if_a.out_addr),  0);
    check("rst_out_last",  int'(if_a.out_last),  0);
    check("rst_b_valid",   int'(if_b.out_valid), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 9; v++) begin
      send_pixels(vecs[v].sel, vecs[v].mode, vecs[v].mul, vecs[v].add,
                  vecs[v].sel ? 64 : 16, 1000);
      idle(vecs[v].sel);
      check_frame(vecs[v].sel, vecs[v].exp, $sformatf("vec%0d", v), 4);
    end

    // Backpressure: hold out_ready low for 5 cycles once the first result appears.
    fork
      send_pixels(1'b0, MODE_AVG, 1, 0, 16, 1000);
      begin
        int budget = 0;
        forever begin
          @(posedge clk);
          #1;
          if (if_a.out_valid) break;
          budget++;
          if (budget > 100) begin
            check("bp_first_valid_timeout", 0, 1);
            break;
          end
        end
        if_a.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("bp_hold_pix",   int'(if_a.out_pixel), 2);
          check("bp_hold_addr",  int'(if_a.out_addr),  0);
          check("bp_hold_valid", int'(if_a.out_valid), 1);
          check("bp_in_ready",   int'(if_a.in_ready),  0);
        end
        @(posedge clk);
        #1;
        if_a.out_ready = 1'b1;
      end
    join
    idle(1'b0);
    check_frame(1'b0, {8'd2, 8'd4, 8'd10, 8'd12}, "bp", 4);

    // Reset mid-frame after 6 pixels: the partial frame must vanish.
    send_pixels(1'b0, MODE_AVG, 1, 0, 6, 1000);
    reset = 1'b0;
    idle(1'b0);
    @(negedge clk);
    check("midrst_out_valid", int'(if_a.out_valid), 0);
    check("midrst_in_ready",  int'(if_a.in_ready),  1);
    check("midrst_out_addr",  int'(if_a.out_addr),  0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    send_pixels(1'b0, MODE_AVG, 1, 0, 16, 1000);
    idle(1'b0);
    check_frame(1'b0, {8'd2, 8'd4, 8'd10, 8'd12}, "midrst", 4);

    // Back-to-back frames; mode flips mid-frame 1 and must only affect frame 2.
    send_pixels(1'b0, MODE_AVG, 1, 0, 16, 8);
    send_pixels(1'b0, MODE_MAX, 1, 0, 16, 1000);
    idle(1'b0);
    check_frame(1'b0, {8'd2, 8'd4, 8'd10, 8'd12}, "b2b_f1", 8);
    check_frame(1'b0, {8'd5, 8'd7, 8'd13, 8'd15}, "b2b_f2", 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
